clk_div_ctrl: RTL and testbench

Run-time programmable clock-enable divider and controller for the VGA demo's clock tree. Replaces the fixed divider with a sequenced one: takes a divisor from the control logic through a load/ack handshake, switches ratio only on a period boundary so no runt periods reach the consumers, and supports clean start/stop. Outputs a single-cycle `tick` enable and a registered 50%-ish `clk_out` square wave for the pixel/timing logic.

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/clk_div_ctrl_if.sv | 36 +++
 rtl/div_counter.sv | 56 +++++
 rtl/clk_div_ctrl.sv | 118 +++++++++++
 tb/tb_clk_div_ctrl.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock-enable divider: FSM encoding and divisor limits.
package clk_div_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int DIV_MIN       = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Control/status bundle between the clock-tree controller and the divider.
interface clk_div_ctrl_if
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             div_ack;
  logic             tick;
  logic             clk_out;
  logic             running;

  modport master (
    output en,
    output div_val,
    output div_load,
    input  div_ack,
    input  tick,
    input  clk_out,
    input  running
  );

  modport slave (
    input  en,
    input  div_val,
    input  div_load,
    output div_ack,
    output tick,
    output clk_out,
    output running
  );

endinterface

// File: rtl/div_counter.sv
// Period counter: wrap detect on the current divisor, registered tick/clk_out computed from next-cycle count and divisor.
module div_counter
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             active,
  input  logic             run_nxt,
  input  logic [CNT_W-1:0] div_cur,
  input  logic [CNT_W-1:0] div_nxt,
  output logic             wrap,
  output logic             tick,
  output logic             clk_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] half_nxt;
  logic             tick_nxt;
  logic             clk_out_nxt;

  always_comb begin
    wrap        = 1'b0;
    cnt_nxt     = '0;
    half_nxt    = '0;
    tick_nxt    = 1'b0;
    clk_out_nxt = 1'b0;

    wrap = active && (cnt == (div_cur - CNT_W'(1)));

    // Entering a run from idle always starts at 0; a stop lands on 0 via the wrap.
    if (run_nxt && active && !wrap) begin
      cnt_nxt = cnt + CNT_W'(1);
    end

    // ceil(N/2) without needing a wider adder
    half_nxt    = (div_nxt >> 1) + {{(CNT_W-1){1'b0}}, div_nxt[0]};
    tick_nxt    = run_nxt && (cnt_nxt == (div_nxt - CNT_W'(1)));
    clk_out_nxt = run_nxt && (cnt_nxt < half_nxt);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      tick    <= tick_nxt;
      clk_out <= clk_out_nxt;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Sequenced clock-enable divider: divisor load/ack handshake, ratio switch only on period boundaries, clean start/stop.
// All outputs are flop-driven; a new divisor is acked in the first cycle it is in force.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int DIV_RESET = 4
) (
  input  logic          clk_in,
  input  logic          rst_n,
  clk_div_ctrl_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] div_cur;
  logic [CNT_W-1:0] div_nxt;
  logic [CNT_W-1:0] pend;
  logic [CNT_W-1:0] pend_nxt;
  logic [CNT_W-1:0] div_req;
  logic             ack_nxt;
  logic             running_nxt;
  logic             active;
  logic             wrap;
  logic             div_ack_q;
  logic             running_q;
  logic             tick_q;
  logic             clk_out_q;

  assign div_req     = (bus.div_val < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : bus.div_val;
  assign active      = (state != ST_IDLE);
  assign running_nxt = (state_nxt != ST_IDLE);

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cur;
    pend_nxt  = pend;
    ack_nxt   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // Divisor lands before the first period so a simultaneous start uses it.
        if (bus.div_load) begin
          div_nxt = div_req;
          ack_nxt = 1'b1;
        end
        if (bus.en) begin
          state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        if (wrap && !bus.en) begin
          state_nxt = ST_IDLE;
          // No further boundary follows a stop, so a load arriving here is applied now.
          if (bus.div_load) begin
            div_nxt = div_req;
            ack_nxt = 1'b1;
          end
        end else if (bus.div_load) begin
          pend_nxt  = div_req;
          state_nxt = ST_PEND;
        end
      end

      ST_PEND: begin
        if (bus.div_load) begin
          pend_nxt = div_req;
        end
        if (wrap) begin
          div_nxt   = bus.div_load ? div_req : pend;
          ack_nxt   = 1'b1;
          state_nxt = bus.en ? ST_RUN : ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      div_cur   <= CNT_W'(DIV_RESET);
      pend      <= '0;
      div_ack_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cur   <= div_nxt;
      pend      <= pend_nxt;
      div_ack_q <= ack_nxt;
      running_q <= running_nxt;
    end
  end

  div_counter #(
    .CNT_W (CNT_W)
  ) u_div_counter (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .active  (active),
    .run_nxt (running_nxt),
    .div_cur (div_cur),
    .div_nxt (div_nxt),
    .wrap    (wrap),
    .tick    (tick_q),
    .clk_out (clk_out_q)
  );

  assign bus.div_ack = div_ack_q;
  assign bus.running = running_q;
  assign bus.tick    = tick_q;
  assign bus.clk_out = clk_out_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed scoreboard bench: the driver queues the expected {tick, clk_out, div_ack, running} per cycle, a monitor compares at negedge.
module tb_clk_div_ctrl;

  logic clk_in = 1'b0;
  logic rst_n;

  clk_div_ctrl_if #(.CNT_W(16)) bus ();

  clk_div_ctrl #(
    .CNT_W     (16),
    .DIV_RESET (4)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0] v;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Drive one cycle's inputs and queue the outputs required during that same cycle.
  task automatic cyc(input logic r, input logic e, input logic ld, input logic [15:0] v,
                     input logic t, input logic c, input logic a, input logic run,
                     input string nm);
    exp_t x;
    @(posedge clk_in);
    #1;
    rst_n        = r;
    bus.en       = e;
    bus.div_load = ld;
    bus.div_val  = v;
    x.v    = {t, c, a, run};
    x.name = nm;
    sb_q.push_back(x);
  endtask

  // One running cycle at position k of an N-cycle period.
  task automatic pcyc(input int n, input int k, input logic ld, input logic [15:0] v,
                      input logic a, input logic e, input string nm);
    cyc(1'b1, e, ld, v, (k == n - 1), (k < (n + 1) / 2), a, 1'b1, nm);
  endtask

  task automatic period(input int n, input logic ack_first, input logic e, input string nm);
    for (int k = 0; k < n; k++) begin
      pcyc(n, k, 1'b0, 16'd0, ack_first && (k == 0), e, nm);
    end
  endtask

  initial begin : monitor
    exp_t       x;
    logic [3:0] got;
    forever begin
      @(negedge clk_in);
      if (sb_q.size() > 0) begin
        x   = sb_q.pop_front();
        got = {bus.tick, bus.clk_out, bus.div_ack, bus.running};
        vectors++;
        if (got !== x.v) begin
          miscompares++;
          $display("FAIL %s: tick/clk_out/ack/running = %b, required %b (t=%0t)",
                   x.name, got, x.v, $time);
        end
      end
    end
  end

  initial begin : driver
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val  = 16'd0;
    repeat (2) @(posedge clk_in);

    cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // Start with the reset divisor: 1,1,0,0 and tick on the 4th cycle.
    cyc(1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "en_rise");
    repeat (3) period(4, 1'b0, 1'b1, "n4");

    // Load 6 at cnt=1: old period finishes, ack with the first 6-cycle period.
    pcyc(4, 0, 1'b0, 16'd0, 1'b0, 1'b1, "n4_pre");
    pcyc(4, 1, 1'b1, 16'd6, 1'b0, 1'b1, "n4_load6");
    pcyc(4, 2, 1'b0, 16'd0, 1'b0, 1'b1, "n4_pend");
    pcyc(4, 3, 1'b0, 16'd0, 1'b0, 1'b1, "n4_pend");
    period(6, 1'b1, 1'b1, "n6_ack");
    period(6, 1'b0, 1'b1, "n6");

    // Clamp: divisors 1 and 0 both run as N=2.
    pcyc(6, 0, 1'b1, 16'd1, 1'b0, 1'b1, "n6_load1");
    for (int k = 1; k < 6; k++) pcyc(6, k, 1'b0, 16'd0, 1'b0, 1'b1, "n6_pend");
    period(2, 1'b1, 1'b1, "n2_from1_ack");
    pcyc(2, 0, 1'b1, 16'd0, 1'b0, 1'b1, "n2_load0");
    pcyc(2, 1, 1'b0, 16'd0, 1'b0, 1'b1, "n2_pend");
    period(2, 1'b1, 1'b1, "n2_from0_ack");
    period(2, 1'b0, 1'b1, "n2");

    // Go to N=4, then two loads (5 then 3) in one period: single ack, N=3 wins.
    pcyc(2, 0, 1'b1, 16'd4, 1'b0, 1'b1, "n2_load4");
    pcyc(2, 1, 1'b0, 16'd0, 1'b0, 1'b1, "n2_pend");
    period(4, 1'b1, 1'b1, "n4_ack");
    pcyc(4, 0, 1'b1, 16'd5, 1'b0, 1'b1, "n4_load5");
    pcyc(4, 1, 1'b1, 16'd3, 1'b0, 1'b1, "n4_load3");
    pcyc(4, 2, 1'b0, 16'd0, 1'b0, 1'b1, "n4_pend");
    pcyc(4, 3, 1'b0, 16'd0, 1'b0, 1'b1, "n4_pend");
    period(3, 1'b1, 1'b1, "n3_ack");
    period(3, 1'b0, 1'b1, "n3");

    // N=6, en glitch mid-period is ignored; en low at the boundary stops cleanly.
    pcyc(3, 0, 1'b1, 16'd6, 1'b0, 1'b1, "n3_load6");
    pcyc(3, 1, 1'b0, 16'd0, 1'b0, 1'b1, "n3_pend");
    pcyc(3, 2, 1'b0, 16'd0, 1'b0, 1'b1, "n3_pend");
    for (int k = 0; k < 6; k++) pcyc(6, k, 1'b0, 16'd0, (k == 0), (k != 2), "n6_en_glitch");
    period(6, 1'b0, 1'b0, "n6_stop");
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "stopped_idle");

    // Reset while a load is pending: no ack ever, divisor back to 4.
    cyc(1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "restart");
    pcyc(6, 0, 1'b0, 16'd0, 1'b0, 1'b1, "n6_run");
    pcyc(6, 1, 1'b1, 16'd3, 1'b0, 1'b1, "n6_load3");
    cyc(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, "rst_in_pend");
    cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "after_rst");
    cyc(1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "en_after_rst");
    period(4, 1'b0, 1'b1, "n4_after_rst");
    period(4, 1'b0, 1'b0, "n4_stop");
    cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, "idle2");

    // Idle load acks next cycle; load plus en together starts with the new N.
    cyc(1'b1, 1'b0, 1'b1, 16'd7, 1'b0, 1'b0, 1'b0, 1'b0, "idle_load7");
    cyc(1'b1, 1'b1, 1'b1, 16'd5, 1'b0, 1'b0, 1'b1, 1'b0, "idle_ack7");
    period(5, 1'b1, 1'b1, "n5_ack");

    // Load in the wrap cycle while running takes effect one boundary later.
    for (int k = 0; k < 4; k++) pcyc(5, k, 1'b0, 16'd0, 1'b0, 1'b1, "n5");
    pcyc(5, 4, 1'b1, 16'd2, 1'b0, 1'b1, "n5_wrap_load2");
    period(5, 1'b0, 1'b1, "n5_pend");
    period(2, 1'b1, 1'b1, "n2_wrap_ack");

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk_in);
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
